// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared memory port to ic or dc one whole transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate the grant when both request together (default: dc wins).
module mem_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int BEATS     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic                   ic_req_rw,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_valid,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic                   dc_req_rw,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  output logic                   owner,
  output logic                   busy
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, CMD, WDATA, RRESP} state_t;
  state_t                 r_state, w_next;
  logic                   r_owner;
  logic [CW-1:0]          r_cnt;
  logic                   w_grant, w_last;
  logic                   w_valid, w_rw, w_dvalid;
  logic [ADDR_BITS-1:0]   w_addr;
  logic [DATA_BITS-1:0]   w_bits;
  logic [DATA_BITS/8-1:0] w_mask;
  logic                   w_cmd_fire, w_data_fire, w_resp_beat;
`ifdef ARB_ROUND_ROBIN_EN
  assign w_grant = (ic_req_valid & dc_req_valid) ? ~r_owner : dc_req_valid;
`else
  assign w_grant = dc_req_valid;
`endif
  assign w_valid     = r_owner ? dc_req_valid      : ic_req_valid;
  assign w_rw        = r_owner ? dc_req_rw         : ic_req_rw;
  assign w_addr      = r_owner ? dc_req_addr       : ic_req_addr;
  assign w_dvalid    = r_owner ? dc_req_data_valid : ic_req_data_valid;
  assign w_bits      = r_owner ? dc_req_data_bits  : ic_req_data_bits;
  assign w_mask      = r_owner ? dc_req_data_mask  : ic_req_data_mask;
  assign w_last      = r_cnt == CW'(BEATS - 1);
  assign w_cmd_fire  = (r_state == CMD) & w_valid & mem_req_ready;
  assign w_data_fire = (r_state == WDATA) & w_dvalid & mem_req_data_ready;
  assign w_resp_beat = (r_state == RRESP) & mem_resp_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && (ic_req_valid || dc_req_valid)) r_owner <= w_grant;
      if (w_cmd_fire) r_cnt <= '0;
      else if (w_data_fire || w_resp_beat) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (ic_req_valid | dc_req_valid) ? CMD : IDLE;
      CMD:     w_next = w_cmd_fire ? (w_rw ? WDATA : RRESP) : CMD;
      WDATA:   w_next = (w_data_fire & w_last) ? IDLE : WDATA;
      default: w_next = (w_resp_beat & w_last) ? IDLE : RRESP;
    endcase
  end
  // Everything not owned by the current phase is forced to zero.
  always_comb begin
    mem_req_valid      = (r_state == CMD) & w_valid;
    mem_req_addr       = (r_state == CMD) ? w_addr : '0;
    mem_req_rw         = (r_state == CMD) & w_rw;
    ic_req_ready       = (r_state == CMD) & ~r_owner & mem_req_ready;
    dc_req_ready       = (r_state == CMD) & r_owner & mem_req_ready;
    mem_req_data_valid = (r_state == WDATA) & w_dvalid;
    mem_req_data_bits  = (r_state == WDATA) ? w_bits : '0;
    mem_req_data_mask  = (r_state == WDATA) ? w_mask : '0;
    ic_req_data_ready  = (r_state == WDATA) & ~r_owner & mem_req_data_ready;
    dc_req_data_ready  = (r_state == WDATA) & r_owner & mem_req_data_ready;
    ic_resp_valid      = w_resp_beat & ~r_owner;
    dc_resp_valid      = w_resp_beat & r_owner;
    ic_resp_data       = (r_state == RRESP) ? mem_resp_data : '0;
    dc_resp_data       = (r_state == RRESP) ? mem_resp_data : '0;
    owner              = r_owner;
    busy               = r_state != IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for arbitration, reset and stalls.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic         ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready, ic_resp_valid;
  logic [27:0]  ic_req_addr;
  logic [127:0] ic_req_data_bits, ic_resp_data;
  logic [15:0]  ic_req_data_mask;
  logic         dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready, dc_resp_valid;
  logic [27:0]  dc_req_addr;
  logic [127:0] dc_req_data_bits, dc_resp_data;
  logic [15:0]  dc_req_data_mask;
  logic         mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data_bits, mem_resp_data;
  logic [15:0]  mem_req_data_mask;
  logic         owner, busy;
  int           checks = 0, errors = 0;
  logic [10:0]  obs;
  typedef struct {logic [8:0] in; logic [10:0] exp;} vec_t;
  vec_t         tv[21];
  logic [127:0] wd[4];
  logic [15:0]  wm[4];
  logic         first, second;
  int           fires;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr), .ic_req_rw(ic_req_rw),
    .ic_req_data_valid(ic_req_data_valid), .ic_req_data_ready(ic_req_data_ready),
    .ic_req_data_bits(ic_req_data_bits), .ic_req_data_mask(ic_req_data_mask),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr), .dc_req_rw(dc_req_rw),
    .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {busy, owner, mem_req_valid, mem_req_rw, mem_req_data_valid, ic_req_ready, dc_req_ready,
                ic_req_data_ready, dc_req_data_ready, ic_resp_valid, dc_resp_valid};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    {ic_req_valid, ic_req_rw, ic_req_data_valid, dc_req_valid, dc_req_rw, dc_req_data_valid} = '0;
    {mem_req_ready, mem_req_data_ready, mem_resp_valid} = '0;
    mem_resp_data = '0;
  endtask

  task automatic beats(input logic who, input logic [127:0] base);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (who) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + 128'(i);
      #1;
      chk("rv_owner", who ? dc_resp_valid : ic_resp_valid, 1'b1);
      chk("rv_other", who ? ic_resp_valid : dc_resp_valid, 1'b0);
      chk("rdata", who ? dc_resp_data : ic_resp_data, base + 128'(i));
      chk("other_ready", who ? ic_req_ready : dc_req_ready, 1'b0);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #1;
    chk("busy_after_read", busy, 1'b0);
    chk("readies_idle", {ic_req_ready, dc_req_ready}, 2'b00);
  endtask

  initial begin
    // in = {ic_v, ic_rw, dc_v, dc_rw, mrdy, ic_dv, dc_dv, mdrdy, rv}
    // exp = {busy, owner, mrv, mrw, mdv, icr, dcr, icdr, dcdr, icrv, dcrv}
    tv[0]  = '{9'b000000000, 11'b00000000000};
    tv[1]  = '{9'b100010000, 11'b00000000000};
    tv[2]  = '{9'b100010000, 11'b10100100000};
    tv[3]  = '{9'b000000001, 11'b10000000010};
    tv[4]  = '{9'b000001011, 11'b10000000010};
    tv[5]  = '{9'b000010001, 11'b10000000010};
    tv[6]  = '{9'b000000000, 11'b10000000000};
    tv[7]  = '{9'b000000001, 11'b10000000010};
    tv[8]  = '{9'b000000001, 11'b00000000000};
    tv[9]  = '{9'b001100000, 11'b00000000000};
    tv[10] = '{9'b001100000, 11'b11110000000};
    tv[11] = '{9'b001110000, 11'b11110010000};
    tv[12] = '{9'b000000110, 11'b11001000100};
    tv[13] = '{9'b000000100, 11'b11001000000};
    tv[14] = '{9'b000000110, 11'b11001000100};
    tv[15] = '{9'b000000100, 11'b11001000000};
    tv[16] = '{9'b000000110, 11'b11001000100};
    tv[17] = '{9'b000000100, 11'b11001000000};
    tv[18] = '{9'b000000110, 11'b11001000100};
    tv[19] = '{9'b000000110, 11'b01000000000};
    tv[20] = '{9'b000000001, 11'b01000000000};
    wd[0] = 128'h11111111_00000000_00000000_0000AAA0;
    wd[1] = 128'h22222222_00000000_00000000_0000AAA1;
    wd[2] = 128'h33333333_00000000_00000000_0000AAA2;
    wd[3] = 128'h44444444_00000000_00000000_0000AAA3;
    wm[0] = 16'hFFFF; wm[1] = 16'h00FF; wm[2] = 16'hF0F0; wm[3] = 16'h0001;
    ic_req_addr = 28'h0000123;
    dc_req_addr = 28'h00000A0;
    ic_req_data_bits = '0;
    ic_req_data_mask = '0;
    dc_req_data_bits = 128'hDCDC_0000_0000_0000_0000_0000_0000_00D5;
    dc_req_data_mask = 16'hFFFF;
    clear_in();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_outputs", obs, 11'b0);
    chk("reset_addr", mem_req_addr, 28'h0);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      {ic_req_valid, ic_req_rw, dc_req_valid, dc_req_rw, mem_req_ready,
       ic_req_data_valid, dc_req_data_valid, mem_req_data_ready, mem_resp_valid} = tv[i].in;
      #1;
      chk($sformatf("vec%0d", i), obs, tv[i].exp);
      if (i == 2) chk("vec_ic_addr", mem_req_addr, 28'h0000123);
      if (i == 12) chk("vec_dc_wdata", mem_req_data_bits, dc_req_data_bits);
    end
`ifdef ARB_ROUND_ROBIN_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    second = ~first;
    @(negedge clk);
    clear_in();
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    #1;
    chk("arb_idle_ready", {ic_req_ready, dc_req_ready}, 2'b00);
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk("arb_first_owner", owner, first);
    chk("arb_first_addr", mem_req_addr, first ? 28'h00000A0 : 28'h0000123);
    chk("arb_first_ready", {ic_req_ready, dc_req_ready}, first ? 2'b01 : 2'b10);
    beats(first, 128'h1000);
    @(negedge clk);
    #1;
    chk("arb_second_owner", owner, second);
    chk("arb_second_addr", mem_req_addr, second ? 28'h00000A0 : 28'h0000123);
    chk("arb_second_ready", {ic_req_ready, dc_req_ready}, second ? 2'b01 : 2'b10);
    beats(second, 128'h2000);
    @(negedge clk);
    clear_in();
    dc_req_valid  = 1'b1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_seq_grant", dc_req_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dc_req_valid   = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 128'h3000 + 128'(i);
      #1;
      chk("rst_seq_beat", dc_resp_valid, 1'b1);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_outputs", obs, 11'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 128'h3002 + 128'(i);
      #1;
      chk("midreset_drop", obs, 11'b0);
      chk("midreset_rdata", ic_resp_data, 128'h0);
    end
    @(negedge clk);
    clear_in();
    ic_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", {busy, mem_req_valid, ic_req_ready}, 3'b110);
      chk("stall_addr", mem_req_addr, 28'h0000123);
    end
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk("stall_fire", ic_req_ready, 1'b1);
    beats(1'b0, 128'h4000);
    @(negedge clk);
    clear_in();
    ic_req_valid  = 1'b1;
    ic_req_rw     = 1'b1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("wr_cmd_rw", {mem_req_valid, mem_req_rw, ic_req_ready}, 3'b111);
    fires = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ic_req_valid       = 1'b0;
      mem_req_ready      = 1'b0;
      ic_req_data_valid  = 1'b1;
      ic_req_data_bits   = wd[fires % 4];
      ic_req_data_mask   = wm[fires % 4];
      mem_req_data_ready = (c % 2) == 0;
      #1;
      if (c < 7) begin
        chk("wr_bits", mem_req_data_bits, wd[fires]);
        chk("wr_mask", mem_req_data_mask, wm[fires]);
        chk("wr_ready", ic_req_data_ready, (c % 2) == 0);
      end
      if (mem_req_data_valid && mem_req_data_ready) fires++;
    end
    chk("wr_fire_count", 128'(fires), 128'd4);
    chk("wr_closed", {busy, mem_req_data_valid, ic_req_data_ready}, 3'b000);
    chk("wr_closed_bits", mem_req_data_bits, 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
